conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Parametrised streaming 3x3 convolution engine for the camera pixel path; next generation of the fixed Sobel
//  block. Sits between the raw-to-grey stage and the display path. Accepts one pixel per iDVAL in raster order.
//  Adds: generic widths and line length, run-time loadable kernel, frame-synchronous kernel and mode updates,
//  border masking, selectable output mapping and normalisation shift.
// PARAMETERS
//  DATA_W   12   pixel width in and out
//  LINE_W   640  pixels per line; also the line-buffer depth
//  COEF_W   8    signed coefficient width
//  SHIFT    0    arithmetic right shift applied to the sum before output mapping
// PORTS
//  iCLK        in   1       clock; all logic on rising edge
//  iRST        in   1       asynchronous, active-high reset
//  iDATA       in   DATA_W  unsigned pixel
//  iDVAL       in   1       pixel valid; one pixel is accepted per cycle in which it is high
//  iSOF        in   1       start of frame; qualifies the same-cycle iDVAL pixel as (0,0)
//  iCOEF_WE    in   1       coefficient write strobe
//  iCOEF_ADDR  in   4       coefficient index 0..8, row-major (0 = top-left); 9..15 are ignored
//  iCOEF_DATA  in   COEF_W  signed coefficient
//  iMODE       in   2       output mapping: 0 = ABS, 1 = CLAMP, 2 = OFFSET, 3 = reserved (treated as CLAMP)
//  oDATA       out  DATA_W  result pixel
//  oDVAL       out  1       result valid
// BEHAVIOUR
//  Reset: oDATA = 0, oDVAL = 0, counters = 0, line buffers cleared.
//  Reset: the shadow and active kernels load the horizontal Sobel kernel {-1,0,1,-2,0,2,-1,0,1}.
//  Reset: the shadow and active mode load ABS. Reset mid-frame aborts everything; all in-flight results are dropped.
//  Counters: col/row advance only on iDVAL. col wraps at LINE_W-1 and increments row. Row saturates at 2^16-1.
//  Counters: iDVAL & iSOF forces the accepted pixel to col = 0, row = 0.
//  Line buffer: two cascaded LINE_W-deep delay lines, advancing only on iDVAL. They give rows r-1 and r-2.
//  Line buffer: a 2-deep horizontal shift register per row completes the 3x3 window.
//  Window: the window formed when pixel (c,r) is accepted is centred on (c-1,r-1).
//  Border: if c < 2 or r < 2, the window crosses the left or top edge. The result is forced to 0 and oDVAL still asserts.
//  Border: there is exactly one output per input pixel.
//  Latency: oDVAL asserts exactly 3 cycles after the accepting iDVAL cycle. Gaps in iDVAL propagate unchanged.
//  Latency: the pipeline is free-running with no back-pressure.
//  Arithmetic: each product is signed, DATA_W+COEF_W+1 bits, with the pixel zero-extended to signed.
//  Arithmetic: the sum is DATA_W+COEF_W+5 bits, so nine products never overflow. Then sum >>> SHIFT.
//  Mapping ABS: |s|, saturated to 2^DATA_W-1.
//  Mapping CLAMP: s < 0 gives 0; s > max gives max; otherwise s.
//  Mapping OFFSET: s + 2^(DATA_W-1), then clamped to [0, max].
//  Coefficient writes: iCOEF_WE writes the shadow bank only.
//  Frame update: the shadow kernel and iMODE (sampled that cycle) are copied to the active set on the cycle iDVAL & iSOF.
//  Frame update: that copied set applies from that pixel's window onward. Results still in the pipe keep the set they started with.
//  Write/SOF collision: a write in the same cycle as iSOF lands in shadow first. The written value is the one copied.
//  Data: no mid-frame change of the active kernel or mode is possible.
// STRUCTURE
//  conv_pkg: MODE_ABS/MODE_CLAMP/MODE_OFFSET localparams, SOBEL_X default kernel constant.
//  conv_pkg: a function for the saturating output mapping.
//  Sub-module: conv_line_buffer (DATA_W, LINE_W, 2 taps, clken). It is inferred RAM plus a read pointer,
//  and replaces the vendor shift-register IP.
//  Top: counters, window registers, coefficient banks, 9-way MAC, 3-stage valid pipe.
// TESTING
//  1 Reset with LINE_W = 8, frame of all pixels 100 in default Sobel mode -> every oDVAL has oDATA = 0; oDVAL = iDVAL delayed 3.
//  2 Vertical step, pixels 0 for c < 4 and 100 for c >= 4, ABS mode.
//    -> results at centres c = 3 and c = 4 (rows >= 1) = 400; all other results 0.
//  3 Same step with kernel negated via writes, then iSOF, CLAMP mode.
//    -> edge results 0; in OFFSET mode edge results = 2048 - 400 = 1648.
//  4 Kernel all 1, SHIFT = 0, pixels 4095 -> ABS output saturates to 4095.
//  5 Kernel all 1, SHIFT = 3, pixels 8 -> output 9.
//  6 Write kernel mid-frame without iSOF -> no output change until the next iSOF.
//    Write at the iSOF cycle -> applies to that frame.
//  7 Random iDVAL gaps (about 30%) vs a reference model -> exact match.
//  8 iRST pulse mid-line -> oDVAL = 0 next cycle; next frame correct.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and the saturating output mapping for the 3x3 convolution stream.
package conv_pkg;

  localparam logic [1:0] MODE_ABS    = 2'd0;
  localparam logic [1:0] MODE_CLAMP  = 2'd1;
  localparam logic [1:0] MODE_OFFSET = 2'd2;

  localparam int KERNEL_TAPS = 9;

  // Horizontal Sobel, row-major with index 0 at the top-left.
  localparam int SOBEL_X [KERNEL_TAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

  // Maps a signed sum onto [0, 2^data_w-1]. Mode 3 falls through to CLAMP.
  function automatic logic signed [63:0] map_output(input logic signed [63:0] s,
                                                    input logic [1:0]         mode,
                                                    input int                 data_w);
    logic signed [63:0] max_v;
    logic signed [63:0] t;
    max_v = (64'sd1 <<< data_w) - 64'sd1;
    case (mode)
      MODE_ABS:    t = (s < 64'sd0) ? -s : s;
      MODE_OFFSET: t = s + (64'sd1 <<< (data_w - 1));
      default:     t = s;
    endcase
    if (t < 64'sd0) begin
      map_output = 64'sd0;
    end else if (t > max_v) begin
      map_output = max_v;
    end else begin
      map_output = t;
    end
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two cascaded LINE_W-deep delay lines that advance only when clken is high.
// tap1 is the pixel one line back, tap2 the pixel two lines back.
module conv_line_buffer #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);

  localparam int PTR_W = $clog2(LINE_W);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LINE_W - 1);

  logic [DATA_W-1:0] mem1 [LINE_W];
  logic [DATA_W-1:0] mem2 [LINE_W];
  logic [PTR_W-1:0]  ptr;

  // Read-before-write at the shared pointer yields exactly LINE_W accepts of delay.
  assign tap1 = mem1[ptr];
  assign tap2 = mem2[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < LINE_W; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
      end
    end else if (clken) begin
      mem1[ptr] <= din;
      mem2[ptr] <= tap1;
      ptr       <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: raster counters, 3x3 window, shadow/active kernel banks,
// nine-way MAC and a three-stage valid pipe with border masking and output mapping.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic              iCOEF_WE,
  input  logic [3:0]        iCOEF_ADDR,
  input  logic [COEF_W-1:0] iCOEF_DATA,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL
);

  // Handshake: a pixel is taken on every cycle iDVAL is high; oDVAL marks exactly one
  // result per taken pixel, three cycles later. There is no ready and the pipe never stalls.

  localparam int COL_W  = $clog2(LINE_W);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = DATA_W + COEF_W + 5;

  logic [COL_W-1:0]  col_cnt, pix_col, col_next;
  logic [15:0]       row_cnt, pix_row, row_next;
  logic              sof_take;

  logic signed [COEF_W-1:0] shadow_k    [KERNEL_TAPS];
  logic signed [COEF_W-1:0] shadow_next [KERNEL_TAPS];
  logic signed [COEF_W-1:0] active_k    [KERNEL_TAPS];
  logic [1:0]               active_mode;

  logic [DATA_W-1:0] line1, line2;
  logic [DATA_W-1:0] win [KERNEL_TAPS];
  logic              v1, border1;

  logic signed [PROD_W-1:0] prod [KERNEL_TAPS];
  logic signed [SUM_W-1:0]  sum_comb;
  logic signed [SUM_W-1:0]  sum2;
  logic                     v2, border2;
  logic [1:0]               mode2;

  logic signed [SUM_W-1:0]  shifted;
  logic [DATA_W-1:0]        mapped;

  assign sof_take = iDVAL & iSOF;

  // Position of the pixel being accepted this cycle and the counter values that follow it.
  always_comb begin
    pix_col  = iSOF ? '0 : col_cnt;
    pix_row  = iSOF ? '0 : row_cnt;
    col_next = pix_col + COL_W'(1);
    row_next = pix_row;
    if (pix_col == COL_W'(LINE_W - 1)) begin
      col_next = '0;
      row_next = (pix_row == 16'hFFFF) ? pix_row : pix_row + 16'd1;
    end
  end

  // A write in the SOF cycle must reach the active bank, so the copy uses the post-write view.
  always_comb begin
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      shadow_next[k] = shadow_k[k];
    end
    if (iCOEF_WE && (iCOEF_ADDR < 4'd9)) begin
      shadow_next[iCOEF_ADDR] = iCOEF_DATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        shadow_k[k] <= COEF_W'(SOBEL_X[k]);
        active_k[k] <= COEF_W'(SOBEL_X[k]);
      end
      active_mode <= MODE_ABS;
    end else begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        shadow_k[k] <= shadow_next[k];
      end
      if (sof_take) begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
          active_k[k] <= shadow_next[k];
        end
        active_mode <= iMODE;
      end
    end
  end

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) u_line_buffer (
    .clk   (iCLK),
    .rst   (iRST),
    .clken (iDVAL),
    .din   (iDATA),
    .tap1  (line1),
    .tap2  (line2)
  );

  // Stage 1: window columns shift left; the new column is rows r-2, r-1, r of this column.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_cnt <= '0;
      row_cnt <= '0;
      v1      <= 1'b0;
      border1 <= 1'b0;
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        win[k] <= '0;
      end
    end else begin
      v1 <= iDVAL;
      if (iDVAL) begin
        col_cnt <= col_next;
        row_cnt <= row_next;
        border1 <= (pix_col < COL_W'(2)) || (pix_row < 16'd2);
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= line2;
        win[5] <= line1;
        win[8] <= iDATA;
      end
    end
  end

  always_comb begin
    sum_comb = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      prod[k]  = PROD_W'($signed({1'b0, win[k]})) * PROD_W'(active_k[k]);
      sum_comb = sum_comb + SUM_W'(prod[k]);
    end
  end

  // Stage 2: the kernel and mode are latched with the sum, so a frame update never
  // touches results already in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v2      <= 1'b0;
      sum2    <= '0;
      border2 <= 1'b0;
      mode2   <= MODE_ABS;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum2    <= sum_comb;
        border2 <= border1;
        mode2   <= active_mode;
      end
    end
  end

  always_comb begin
    shifted = sum2 >>> SHIFT;
    mapped  = DATA_W'(map_output(64'(shifted), mode2, DATA_W));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= v2;
      if (v2) begin
        oDATA <= border2 ? '0 : mapped;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: two instances (SHIFT 0 and 3) share the stimulus
// and are compared against a frame-level reference model.
module tb_conv3x3_stream;

  localparam int DATA_W = 12;
  localparam int LINE_W = 8;
  localparam int COEF_W = 8;
  localparam int MAX_ROWS = 16;
  localparam int SOBEL [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

  logic              iCLK = 1'b0;
  logic              iRST;
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL, iSOF, iCOEF_WE;
  logic [3:0]        iCOEF_ADDR;
  logic [COEF_W-1:0] iCOEF_DATA;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] odata_a, odata_b;
  logic              odval_a, odval_b;

  conv3x3_stream #(.DATA_W(DATA_W), .LINE_W(LINE_W), .COEF_W(COEF_W), .SHIFT(0)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR), .iCOEF_DATA(iCOEF_DATA), .iMODE(iMODE),
    .oDATA(odata_a), .oDVAL(odval_a)
  );

  conv3x3_stream #(.DATA_W(DATA_W), .LINE_W(LINE_W), .COEF_W(COEF_W), .SHIFT(3)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR), .iCOEF_DATA(iCOEF_DATA), .iMODE(iMODE),
    .oDATA(odata_b), .oDVAL(odval_b)
  );

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model state ----------------
  int img [MAX_ROWS][LINE_W];
  int m_col, m_row;
  int shadow_k [9];
  int active_k [9];
  int act_mode;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_a_q [$];
  logic [DATA_W-1:0] exp_b_q [$];
  logic [DATA_W-1:0] obs_a_q [$];
  logic [DATA_W-1:0] obs_b_q [$];
  bit exp_v [$];
  bit obs_v [$];
  bit obs_vb [$];

  function automatic int ref_pixel(input int c, input int r, input int shift);
    int s;
    s = 0;
    if (c < 2 || r < 2) return 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        s += img[r-2+dy][c-2+dx] * active_k[dy*3+dx];
    s = s >>> shift;
    case (act_mode)
      0: s = (s < 0) ? -s : s;
      2: s = s + 2048;
      default: ;
    endcase
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      shadow_k[k] = SOBEL[k];
      active_k[k] = SOBEL[k];
    end
    act_mode = 0;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic clear_queues();
    exp_a_q.delete(); exp_b_q.delete(); obs_a_q.delete(); obs_b_q.delete();
    exp_v.delete(); obs_v.delete(); obs_vb.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: apply inputs, update the model, record what the DUTs show this cycle.
  task automatic drive(input bit dv, input int pix, input bit sof);
    iDVAL = dv;
    iDATA = DATA_W'(pix);
    iSOF  = sof;
    if (iCOEF_WE && iCOEF_ADDR < 4'd9) shadow_k[iCOEF_ADDR] = int'($signed(iCOEF_DATA));
    if (dv) begin
      if (sof) begin
        m_col = 0;
        m_row = 0;
        active_k = shadow_k;
        act_mode = int'(iMODE);
      end
      img[m_row][m_col] = pix;
      exp_a_q.push_back(DATA_W'(ref_pixel(m_col, m_row, 0)));
      exp_b_q.push_back(DATA_W'(ref_pixel(m_col, m_row, 3)));
      if (m_col == LINE_W - 1) begin
        m_col = 0;
        if (m_row < MAX_ROWS - 1) m_row++;
      end else begin
        m_col++;
      end
    end
    exp_v.push_back(dv);
    @(negedge iCLK);
    obs_v.push_back(odval_a);
    obs_vb.push_back(odval_b);
    if (odval_a) obs_a_q.push_back(odata_a);
    if (odval_b) obs_b_q.push_back(odata_b);
    @(posedge iCLK);
    #1;
    iCOEF_WE = 1'b0;
    iSOF     = 1'b0;
    iDVAL    = 1'b0;
  endtask

  task automatic load_kernel(input int kern [9]);
    for (int k = 0; k < 9; k++) begin
      iCOEF_WE   = 1'b1;
      iCOEF_ADDR = 4'(k);
      iCOEF_DATA = COEF_W'(kern[k]);
      drive(1'b0, 0, 1'b0);
    end
  endtask

  // kind 0: constant val, 1: vertical step at c = 4, 2: random pixels.
  task automatic send_frame(input int rows, input int kind, input int val,
                            input int gap_pct, input bit use_sof);
    int pix;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
          repeat ($urandom_range(1, 3)) drive(1'b0, 0, 1'b0);
        case (kind)
          0: pix = val;
          1: pix = (c >= 4) ? 100 : 0;
          default: pix = int'($urandom_range(0, 4095));
        endcase
        drive(1'b1, pix, use_sof && r == 0 && c == 0);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iRST = 1'b1;
    iDVAL = 1'b1; iSOF = 1'b1; iDATA = 12'hABC;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    checks++; if (odval_a !== 1'b0) begin errors++; $display("FAIL reset dval_a: got %b want 0", odval_a); end
    checks++; if (odata_a !== 12'd0) begin errors++; $display("FAIL reset data_a: got %0d want 0", odata_a); end
    checks++; if (odval_b !== 1'b0) begin errors++; $display("FAIL reset dval_b: got %b want 0", odval_b); end
    checks++; if (odata_b !== 12'd0) begin errors++; $display("FAIL reset data_b: got %0d want 0", odata_b); end
    iDVAL = 1'b0; iSOF = 1'b0;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    model_reset();
    @(posedge iCLK); #1;
  endtask

  task automatic test_flat_frame();
    clear_queues();
    iMODE = 2'd0;
    send_frame(4, 0, 100, 0, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < obs_v.size(); i++) begin
      bit want;
      want = (i < 3) ? 1'b0 : exp_v[i-3];
      checks++;
      if (obs_v[i] !== want || obs_vb[i] !== want) begin
        errors++; $display("FAIL flat dval cycle %0d: got %b/%b want %b", i, obs_v[i], obs_vb[i], want);
      end
    end
    checks++;
    if (obs_a_q.size() != exp_a_q.size() || obs_b_q.size() != exp_b_q.size()) begin
      errors++; $display("FAIL flat count: got %0d/%0d want %0d", obs_a_q.size(), obs_b_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size(); i++) begin
      checks++;
      if (obs_a_q[i] !== 12'd0) begin errors++; $display("FAIL flat data %0d: got %0d want 0", i, obs_a_q[i]); end
    end
  endtask

  task automatic test_vertical_step();
    int neg [9];
    clear_queues();
    iMODE = 2'd0;
    send_frame(4, 1, 0, 0, 1'b1);
    for (int k = 0; k < 9; k++) neg[k] = -SOBEL[k];
    load_kernel(neg);
    iMODE = 2'd1;
    send_frame(4, 1, 0, 0, 1'b1);
    iMODE = 2'd2;
    send_frame(4, 1, 0, 0, 1'b1);
    iMODE = 2'd3;
    send_frame(3, 1, 0, 0, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < obs_v.size(); i++) begin
      bit want;
      want = (i < 3) ? 1'b0 : exp_v[i-3];
      checks++;
      if (obs_v[i] !== want || obs_vb[i] !== want) begin
        errors++; $display("FAIL step dval cycle %0d: got %b/%b want %b", i, obs_v[i], obs_vb[i], want);
      end
    end
    checks++;
    if (obs_a_q.size() != exp_a_q.size() || obs_b_q.size() != exp_b_q.size()) begin
      errors++; $display("FAIL step count: got %0d/%0d want %0d", obs_a_q.size(), obs_b_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size() && i < obs_b_q.size(); i++) begin
      checks++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
        errors++; $display("FAIL step data %0d: got %0d/%0d want %0d/%0d", i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
      end
    end
  endtask

  task automatic test_saturation_shift();
    int ones [9];
    clear_queues();
    for (int k = 0; k < 9; k++) ones[k] = 1;
    load_kernel(ones);
    iMODE = 2'd0;
    send_frame(3, 0, 4095, 0, 1'b1);
    send_frame(3, 0, 8, 0, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < obs_v.size(); i++) begin
      bit want;
      want = (i < 3) ? 1'b0 : exp_v[i-3];
      checks++;
      if (obs_v[i] !== want || obs_vb[i] !== want) begin
        errors++; $display("FAIL sat dval cycle %0d: got %b/%b want %b", i, obs_v[i], obs_vb[i], want);
      end
    end
    checks++;
    if (obs_a_q.size() != exp_a_q.size() || obs_b_q.size() != exp_b_q.size()) begin
      errors++; $display("FAIL sat count: got %0d/%0d want %0d", obs_a_q.size(), obs_b_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size() && i < obs_b_q.size(); i++) begin
      checks++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
        errors++; $display("FAIL sat data %0d: got %0d/%0d want %0d/%0d", i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
      end
    end
  endtask

  task automatic test_kernel_update();
    clear_queues();
    load_kernel(SOBEL);
    iMODE = 2'd0;
    // Mid-frame write must stay in the shadow bank until the next SOF.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        if (r == 2 && c == 3) begin
          iCOEF_WE = 1'b1; iCOEF_ADDR = 4'd5; iCOEF_DATA = 8'sd7;
          iMODE = 2'd2;
        end
        drive(1'b1, int'($urandom_range(0, 4095)), r == 0 && c == 0);
      end
    end
    // Write in the SOF cycle applies to the new frame.
    iCOEF_WE = 1'b1; iCOEF_ADDR = 4'd3; iCOEF_DATA = 8'sd5;
    iMODE = 2'd0;
    send_frame(4, 2, 0, 0, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < obs_v.size(); i++) begin
      bit want;
      want = (i < 3) ? 1'b0 : exp_v[i-3];
      checks++;
      if (obs_v[i] !== want || obs_vb[i] !== want) begin
        errors++; $display("FAIL kupd dval cycle %0d: got %b/%b want %b", i, obs_v[i], obs_vb[i], want);
      end
    end
    checks++;
    if (obs_a_q.size() != exp_a_q.size() || obs_b_q.size() != exp_b_q.size()) begin
      errors++; $display("FAIL kupd count: got %0d/%0d want %0d", obs_a_q.size(), obs_b_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size() && i < obs_b_q.size(); i++) begin
      checks++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
        errors++; $display("FAIL kupd data %0d: got %0d/%0d want %0d/%0d", i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
      end
    end
  endtask

  task automatic test_random_gaps();
    int kern [9];
    clear_queues();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 9; k++) kern[k] = int'($urandom_range(0, 255)) - 128;
      load_kernel(kern);
      iCOEF_WE = 1'b1; iCOEF_ADDR = 4'(12 + f); iCOEF_DATA = COEF_W'($urandom_range(0, 255));
      drive(1'b0, 0, 1'b0);
      iMODE = 2'($urandom_range(0, 3));
      send_frame(5, 2, 0, 30, 1'b1);
    end
    repeat (4) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < obs_v.size(); i++) begin
      bit want;
      want = (i < 3) ? 1'b0 : exp_v[i-3];
      checks++;
      if (obs_v[i] !== want || obs_vb[i] !== want) begin
        errors++; $display("FAIL rand dval cycle %0d: got %b/%b want %b", i, obs_v[i], obs_vb[i], want);
      end
    end
    checks++;
    if (obs_a_q.size() != exp_a_q.size() || obs_b_q.size() != exp_b_q.size()) begin
      errors++; $display("FAIL rand count: got %0d/%0d want %0d", obs_a_q.size(), obs_b_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size() && i < obs_b_q.size(); i++) begin
      checks++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
        errors++; $display("FAIL rand data %0d: got %0d/%0d want %0d/%0d", i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    int ones [9];
    for (int k = 0; k < 9; k++) ones[k] = 1;
    load_kernel(ones);
    iMODE = 2'd1;
    for (int i = 0; i < LINE_W + 4; i++) drive(1'b1, int'($urandom_range(0, 4095)), i == 0);
    iRST = 1'b1;
    #1;
    checks++; if (odval_a !== 1'b0 || odval_b !== 1'b0) begin errors++; $display("FAIL rstmid dval: got %b/%b want 0", odval_a, odval_b); end
    checks++; if (odata_a !== 12'd0 || odata_b !== 12'd0) begin errors++; $display("FAIL rstmid data: got %0d/%0d want 0", odata_a, odata_b); end
    @(posedge iCLK); #1;
    iRST = 1'b0;
    model_reset();
    clear_queues();
    // No SOF: the reset values of counters, active kernel and mode must carry this frame.
    iMODE = 2'd2;
    send_frame(4, 2, 0, 0, 1'b0);
    iMODE = 2'd0;
    send_frame(3, 2, 0, 0, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0);
    for (int i = 0; i < obs_v.size(); i++) begin
      bit want;
      want = (i < 3) ? 1'b0 : exp_v[i-3];
      checks++;
      if (obs_v[i] !== want || obs_vb[i] !== want) begin
        errors++; $display("FAIL rstmid dval cycle %0d: got %b/%b want %b", i, obs_v[i], obs_vb[i], want);
      end
    end
    checks++;
    if (obs_a_q.size() != exp_a_q.size() || obs_b_q.size() != exp_b_q.size()) begin
      errors++; $display("FAIL rstmid count: got %0d/%0d want %0d", obs_a_q.size(), obs_b_q.size(), exp_a_q.size());
    end
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size() && i < obs_b_q.size(); i++) begin
      checks++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_b_q[i] !== exp_b_q[i]) begin
        errors++; $display("FAIL rstmid data %0d: got %0d/%0d want %0d/%0d", i, obs_a_q[i], obs_b_q[i], exp_a_q[i], exp_b_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    iRST = 1'b1;
    iDATA = '0; iDVAL = 1'b0; iSOF = 1'b0;
    iCOEF_WE = 1'b0; iCOEF_ADDR = '0; iCOEF_DATA = '0; iMODE = 2'd0;
    model_reset();
    test_reset();
    test_flat_frame();
    test_vertical_step();
    test_saturation_shift();
    test_kernel_update();
    test_random_gaps();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
